// File: rtl/rand_candidate_sampler.sv
// Samples the free-running LFSR word after a fixed skip, shapes it into an RSA prime candidate and hands it out via valid/ready.
// Optional repetition-count health test enabled by defining RAND_SAMPLER_HEALTH_EN.
module rand_candidate_sampler #(
  parameter int WORD_WIDTH  = 512,
  parameter int SKIP_CYCLES = 8,
  parameter int REP_LIMIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] rand_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [WORD_WIDTH-1:0] cand_out,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(SKIP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKIP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_OUT  = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  if ((WORD_WIDTH < 4) || (SKIP_CYCLES < 1) || (REP_LIMIT < 2)) begin : g_param_err
    $error("rand_candidate_sampler: illegal parameter combination");
  end

  // Top two bits give the full bit length, LSB makes the candidate odd.
  function automatic logic [WORD_WIDTH-1:0] shape_candidate(input logic [WORD_WIDTH-1:0] raw);
    logic [WORD_WIDTH-1:0] s;
    s                 = raw;
    s[WORD_WIDTH-1]   = 1'b1;
    s[WORD_WIDTH-2]   = 1'b1;
    s[0]              = 1'b1;
    return s;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   cand_q, cand_d;
  logic                    req_ready_q;
  logic                    busy_q;
  logic                    cand_valid_q;
  logic                    err_q;
  logic                    capture_s;
  logic                    raw_zero_s;
  logic                    rep_fail_s;

  assign capture_s  = (state_q == S_SKIP) && (cnt_q == CNT_LAST);
  assign raw_zero_s = (rand_in == {WORD_WIDTH{1'b0}});

`ifdef RAND_SAMPLER_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [WORD_WIDTH-1:0] prev_raw_q, prev_raw_d;
  logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;

  // Repetition-count update on every capture; a run of REP_LIMIT equal samples is fatal.
  always_comb begin
    prev_raw_d = prev_raw_q;
    rep_cnt_d  = rep_cnt_q;
    rep_fail_s = 1'b0;
    if (capture_s) begin
      if ((rand_in == prev_raw_q) && (rep_cnt_q != {REP_W{1'b0}})) begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end else begin
        rep_cnt_d = REP_W'(1);
      end
      prev_raw_d = rand_in;
      rep_fail_s = (rep_cnt_d == REP_W'(REP_LIMIT));
    end else begin
      rep_fail_s = 1'b0;
    end
  end

  // Health history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_raw_q <= {WORD_WIDTH{1'b0}};
      rep_cnt_q  <= {REP_W{1'b0}};
    end else begin
      prev_raw_q <= prev_raw_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end
`else
  assign rep_fail_s = 1'b0;
`endif

  // Next-state logic for the request / skip / output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SKIP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SKIP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (capture_s) begin
          if (raw_zero_s || rep_fail_s) begin
            state_d = S_ERR;
          end else begin
            state_d = S_OUT;
            cand_d  = shape_candidate(rand_in);
          end
        end else begin
          state_d = S_SKIP;
        end
      end
      S_OUT: begin
        if (cand_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // State plus status outputs, registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      cand_q       <= {WORD_WIDTH{1'b0}};
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      req_ready_q  <= (state_d == S_IDLE);
      busy_q       <= (state_d == S_SKIP) || (state_d == S_OUT);
      cand_valid_q <= (state_d == S_OUT);
      err_q        <= (state_d == S_ERR);
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign cand_valid = cand_valid_q;
  assign err        = err_q;
  assign cand_out   = cand_q;

endmodule

// File: doc/rand_candidate_sampler.md
Name: rand_candidate_sampler

Overview:
Consumer end of the LFSR random word stream. On request, it lets the free-running LFSR advance a fixed number of cycles, captures one word and shapes it into an RSA prime candidate: MSB, MSB-1 and LSB are forced to 1. The candidate is handed downstream (primality tester) over a valid/ready handshake. Sits between `lfsr` and the key-generation controller, and flags LFSR lock-up via a sticky error.

Parameters:
- WORD_WIDTH, 512, width of the random word and the candidate; must be >= 4.
- SKIP_CYCLES, 8, LFSR cycles skipped between request accept and capture; must be >= 1.
- REP_LIMIT, 3, consecutive identical raw samples that trigger an error; health feature only; must be >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rand_in  in  WORD_WIDTH  raw word from `lfsr` `rand_out`; may change every cycle.
- req_valid  in  1  controller requests a new candidate.
- req_ready  out  1  high only in IDLE.
- cand_valid  out  1  candidate available.
- cand_ready  in  1  downstream accepts the candidate.
- cand_out  out  WORD_WIDTH  shaped candidate.
- busy  out  1  high in SKIP or OUT.
- err  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; cand_out = 0; cand_valid = 0; err = 0; skip counter = 0; health registers = 0.
  - req_ready = 1 and busy = 0, because both decode from state.
- States: IDLE, SKIP, OUT, ERR. req_ready, busy and cand_valid are decoded from state. cand_valid = (state == OUT).
- IDLE:
  - Request is accepted at the rising edge where req_valid & req_ready.
  - Next state is SKIP, with counter = 0.
- SKIP:
  - Counter increments each cycle.
  - At the edge where counter == SKIP_CYCLES-1, the block samples rand_in.
  - If the raw sample == 0 (LFSR lock-up): next state ERR, cand_out unchanged.
  - Otherwise: cand_out <= rand_in with bits [W-1], [W-2] and [0] set; next state OUT.
  - Latency: cand_valid rises exactly SKIP_CYCLES cycles after the accept edge.
- OUT:
  - cand_out and cand_valid are held stable regardless of rand_in until cand_valid & cand_ready at a rising edge.
  - After that handshake: next state IDLE; cand_out keeps its last value.
  - req_valid is ignored in OUT. A new request is accepted at the earliest one cycle after the handshake.
  - cand_ready asserted while cand_valid is low has no effect.
- ERR:
  - err = 1, req_ready = 0, cand_valid = 0, busy = 0.
  - Terminal state; only reset exits.
- Reset mid-operation (SKIP or OUT): the in-flight request is discarded and all outputs take their reset values immediately. There is no pending state after reset release.
- Counter width: $clog2(SKIP_CYCLES)+1 bits; no wrap-around within SKIP.

Optional Feature:
- Macro: RAND_SAMPLER_HEALTH_EN
- With the macro defined (repetition-count health test):
  - The block keeps the previous raw sample prev_raw and a counter rep_cnt, both 0 at reset.
  - On each capture:
    - If raw == prev_raw and rep_cnt != 0: rep_cnt++.
    - Otherwise: rep_cnt = 1.
    - prev_raw <= raw.
  - If the updated rep_cnt == REP_LIMIT, next state is ERR instead of OUT, and no candidate is emitted.
  - The zero check still applies.
- Without the macro: no prev_raw or rep_cnt registers exist; only the zero check can set err.

Test Plan:
- Use WORD_WIDTH=16, SKIP_CYCLES=4, REP_LIMIT=3, and drive rand_in from the bench.
1. Reset: hold rst=0 for 3 cycles -> cand_valid=0, cand_out=16'h0000, err=0, req_ready=1, busy=0. Release -> outputs unchanged until a request.
2. Basic request: pulse req_valid for 1 cycle, with rand_in=16'h1234 at the capture edge and cand_ready=1 -> cand_valid high exactly 4 cycles after accept, cand_out=16'hD235, high for 1 cycle, then req_ready=1.
3. Backpressure: same request, with cand_ready=0 for 5 cycles while rand_in toggles -> cand_out stays 16'hD235 and cand_valid stays high. Raise cand_ready -> one handshake, then IDLE.
4. Lock-up: rand_in=16'h0000 at capture -> err=1, req_ready=0, cand_valid never asserts. Further req_valid is ignored until reset; after reset, err=0.
5. Health test: rand_in fixed at 16'hABCD for 3 back-to-back requests.
   - Macro on: first two give cand_out=16'hEBCD; the third sets err=1 with no cand_valid.
   - Macro off: all three give 16'hEBCD and err stays 0.
6. Reset mid-SKIP: assert rst=0 two cycles after accept -> cand_valid=0, busy=0 immediately. After release, a request with rand_in=16'h0F0E gives 16'hCF0F after 4 cycles.
